forward_hazard_unit: RTL and testbench

Pipeline control block that drives the 2-bit select lines of the EX-stage 3-to-1 operand multiplexers (A and B) and the load-use stall of the 5-stage MIPS datapath. It keeps its own shadow copy of the EX, MEM and WB stage register-destination information. It compares source registers against that state to choose between register file, EX/MEM result and MEM/WB result. It also counts stall cycles for performance measurement.

---
 rtl/forward_hazard_unit.sv | 129 ++++++++++++
 tb/tb_forward_hazard_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Forwarding-mux select and load-use stall control for a 5-stage MIPS pipe.
// Ports: Clk/Reset, ID-stage instruction info, flush -> fwd_a/b_sel, stall, stall_cnt.
module forward_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } mem_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
  } wb_rec_t;

  ex_rec_t          ex_q, ex_d;
  mem_rec_t         mem_q, mem_d;
  wb_rec_t          wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Newest producer (MEM) wins over older one (WB); $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] src,
    input ex_rec_t    ex,
    input mem_rec_t   mem,
    input wb_rec_t    wb
  );
    logic active;
    active = ex.valid & use_src & (src != 5'd0);
    if (active & mem.valid & mem.reg_write & (mem.dst == src))
      return 2'b01;
    else if (active & wb.valid & wb.reg_write & (wb.dst == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(ex_q.use_rs, ex_q.rs, ex_q, mem_q, wb_q);
    fwd_b_sel = fwd_sel(ex_q.use_rt, ex_q.rt, ex_q, mem_q, wb_q);
  end

  // Only a load still in EX stalls; a load in MEM is covered by WB forwarding.
  always_comb begin
    stall = id_valid & ~flush & ex_q.valid & ex_q.mem_read
          & (ex_q.dst != 5'd0)
          & ((id_use_rs & (id_rs == ex_q.dst))
           | (id_use_rt & (id_rt == ex_q.dst)));
  end

  always_comb begin
    ex_d  = '0;
    mem_d = '0;
    wb_d  = '0;
    cnt_d = cnt_q;

    wb_d.valid     = mem_q.valid;
    wb_d.dst       = mem_q.dst;
    wb_d.reg_write = mem_q.reg_write;

    mem_d.valid     = ex_q.valid;
    mem_d.dst       = ex_q.dst;
    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;

    if (id_valid & ~stall & ~flush) begin
      ex_d.valid     = 1'b1;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.use_rs    = id_use_rs;
      ex_d.use_rt    = id_use_rt;
      ex_d.dst       = id_dst;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end

    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding, load-use stall,
// flush, $0 handling, counter saturation and asynchronous reset.
module tb_forward_hazard_unit;

  localparam int CW = 3;

  logic          Clk;
  logic          Reset;
  logic          id_valid;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [4:0]    id_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  forward_hazard_unit #(.CNT_W(CW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_dst(id_dst),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .flush(flush),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .stall(stall),
    .stall_cnt(stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    flush = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_a", fwd_a_sel, 0);
    chk("rst_b", fwd_b_sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // add $3<-$1,$2 ; sub $4<-$3,$5
    issue(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    issue(1, 3, 5, 1, 1, 4, 1, 0);
    chk("b2b_stall", stall, 0);
    tick();
    chk("b2b_a", fwd_a_sel, 1);
    chk("b2b_b", fwd_b_sel, 0);

    // add $10 ; and $7<-$8,$9 ; or $11<-$10,$10
    issue(1, 1, 2, 1, 1, 10, 1, 0);
    tick();
    issue(1, 8, 9, 1, 1, 7, 1, 0);
    tick();
    issue(1, 10, 10, 1, 1, 11, 1, 0);
    tick();
    chk("d2_a", fwd_a_sel, 2);
    chk("d2_b", fwd_b_sel, 2);

    // $12 written twice, consumer or $13<-$12,$0
    issue(1, 1, 1, 1, 1, 12, 1, 0);
    tick();
    issue(1, 12, 1, 1, 1, 12, 1, 0);
    tick();
    issue(1, 12, 0, 1, 1, 13, 1, 0);
    tick();
    chk("dbl_a", fwd_a_sel, 1);
    chk("dbl_b_r0", fwd_b_sel, 0);

    // lw $2 ; add $6<-$2,$7
    issue(1, 1, 0, 1, 0, 2, 1, 1);
    tick();
    issue(1, 2, 7, 1, 1, 6, 1, 0);
    chk("lu_stall", stall, 1);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_stall_end", stall, 0);
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_bubble_a", fwd_a_sel, 0);
    tick();
    chk("lu_a", fwd_a_sel, 2);
    chk("lu_b", fwd_b_sel, 0);
    chk("lu_stall2", stall, 0);

    // lw $0 ; add $6<-$0,$0
    issue(1, 1, 0, 1, 0, 0, 1, 1);
    tick();
    issue(1, 0, 0, 1, 1, 6, 1, 0);
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_a", fwd_a_sel, 0);
    chk("r0_b", fwd_b_sel, 0);
    chk("r0_cnt", stall_cnt, 1);

    // lw $5 ; add $6<-$5,$1 with flush ; or $8<-$6,$1
    issue(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    flush = 1'b1;
    issue(1, 5, 1, 1, 1, 6, 1, 0);
    chk("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("fl_cnt", stall_cnt, 1);
    issue(1, 6, 1, 1, 1, 8, 1, 0);
    chk("fl_stall2", stall, 0);
    tick();
    chk("fl_bubble_a", fwd_a_sel, 0);
    chk("fl_cnt2", stall_cnt, 1);

    // saturating counter: 7 more load-use hazards, limit 7
    for (int i = 0; i < 7; i++) begin
      issue(1, 1, 0, 1, 0, 2, 1, 1);
      tick();
      issue(1, 1, 2, 1, 1, 6, 1, 0);
      chk("sat_stall", stall, 1);
      tick();
      chk("sat_cnt", stall_cnt, (i + 2 > 7) ? 7 : i + 2);
      tick();
    end

    // add $3 ; lw $2<-[$3] ; add $6<-$2 then async reset
    issue(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    issue(1, 3, 0, 1, 0, 2, 1, 1);
    tick();
    issue(1, 2, 0, 1, 0, 6, 1, 0);
    chk("pre_rst_a", fwd_a_sel, 1);
    chk("pre_rst_stall", stall, 1);
    #1;
    Reset = 1'b1;
    #1;
    chk("arst_a", fwd_a_sel, 0);
    chk("arst_b", fwd_b_sel, 0);
    chk("arst_stall", stall, 0);
    chk("arst_cnt", stall_cnt, 0);
    @(negedge Clk);
    Reset = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    issue(1, 2, 3, 1, 1, 9, 1, 0);
    tick();
    chk("post_rst_a", fwd_a_sel, 0);
    chk("post_rst_b", fwd_b_sel, 0);
    chk("post_rst_cnt", stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
